fv_enc_mult_sched: RTL and testbench
====================================

Name: fv_enc_mult_sched

Overview:
- Scheduler for the shared polynomial multiplier in the FV encryption datapath.
- Arbitrates NREQ requesters (ct0 path p0*u and ct1 path p1*u by default) with round-robin priority.
- For each granted job it sequences the multiplier: stream N operand coefficients in, start, wait for completion, stream N result coefficients out, then signal done to the owner.

Parameters:
- N, 16, polynomial length (coefficients per operand/result); power of 2, >=2.
- NREQ, 2, number of requesters; >=2.
- TO_CYCLES, 4096, watchdog limit in cycles for the WAIT state; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- locked  input  1  PLL locked, active high; no new grant is issued while low.
- req  input  NREQ  per-requester job request; level, held until the matching done pulse.
- grant  output  NREQ  one-hot owner of the multiplier; all zero when idle.
- ld_valid  output  1  operand coefficient load strobe to the multiplier.
- ld_idx  output  $clog2(N)  operand coefficient index, 0..N-1.
- mul_start  output  1  one-cycle start pulse to the multiplier.
- mul_done  input  1  one-cycle completion pulse from the multiplier.
- rd_valid  output  1  result coefficient read strobe.
- rd_idx  output  $clog2(N)  result coefficient index, 0..N-1.
- done  output  NREQ  one-cycle job-complete pulse to the owner; one-hot.
- busy  output  1  high in every state except IDLE.
- err  output  1  sticky watchdog error flag; constant 0 when the optional feature is not compiled in.

Behaviour:
- Reset values (async assert, sync release): state=IDLE, grant=0, ld_valid=0, ld_idx=0, mul_start=0, rd_valid=0, rd_idx=0, done=0, busy=0, err=0, priority pointer=0.
- All outputs are registered.
- FSM states: IDLE, LOAD, START, WAIT, DRAIN, RELEASE.
- IDLE:
  - If locked=1 and req!=0, grant the first set req bit searching upward from the pointer, with wrap-around.
  - Next state is LOAD; grant is registered and held through RELEASE.
  - If locked=0, stay in IDLE regardless of req.
- LOAD:
  - ld_valid=1 for exactly N consecutive cycles; ld_idx=0..N-1.
  - After the cycle with ld_idx=N-1, go to START; ld_idx returns to 0.
- START: mul_start=1 for one cycle, then go to WAIT.
- WAIT:
  - Hold until mul_done=1, then go to DRAIN.
  - mul_done is ignored in every other state.
  - A mul_done in the same cycle as mul_start is not recognised; the earliest recognised mul_done is the first WAIT cycle.
- DRAIN:
  - rd_valid=1 for exactly N cycles; rd_idx=0..N-1.
  - After rd_idx=N-1, go to RELEASE.
- RELEASE:
  - done=grant for one cycle; the pointer advances to (owner+1) mod NREQ.
  - Next cycle: grant=0 and state=IDLE. A new grant is therefore possible at the earliest 2 cycles after done.
- Fixed latency: IDLE grant to first ld_valid = 1 cycle.
- Job length excluding multiplier time: 2N+3 cycles (LOAD N, START 1, DRAIN N, RELEASE 1, IDLE 1).
- req deassert mid-job by the owner is ignored; the job completes.
- A requester whose req stays high after done re-competes at the normal priority.
- locked falling mid-job does not abort the job; it only blocks the next grant.
- Index counters wrap from N-1 to 0, never beyond.
- rst asserted mid-job returns everything to reset values immediately. No done pulse is produced for the aborted job.

Optional Feature:
- Macro: FV_ENC_MULT_SCHED_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT.
  - If TO_CYCLES cycles elapse without mul_done, err is set (sticky until rst) and the FSM goes to RELEASE. done is pulsed so the owner is not hung, and DRAIN is skipped.
- When not defined: no counter; WAIT waits indefinitely; err is tied to 0.

Test Plan:
- Single job: locked=1, req=2'b01, multiplier returns mul_done 20 cycles after mul_start -> grant=01 next cycle; ld_valid for 16 cycles with idx 0..15; one mul_start; rd_valid for 16 cycles with idx 0..15; done=01 for 1 cycle; busy low afterwards.
- Contention: req=2'b11 held continuously after reset -> grants in order 01, 10, 01, 10. Each done matches its grant, and grant is never multi-hot.
- Lock gating: locked=0 with req=2'b01 for 50 cycles -> grant=0, busy=0. locked rises -> grant=01 the cycle after.
- Mid-job reset: assert rst during DRAIN at rd_idx=7 -> all outputs 0 in that same cycle (async). No done pulse. A fresh job after release starts at ld_idx=0.
- Early/stray mul_done: pulse mul_done during LOAD, then again 5 cycles after mul_start -> the LOAD pulse is ignored; DRAIN starts the cycle after the second pulse.
- With FV_ENC_MULT_SCHED_TIMEOUT_EN and TO_CYCLES=64, mul_done never asserted -> err=1 and done pulse 64 cycles into WAIT; no rd_valid; err stays 1 until rst.

Source files
------------

// File: rtl/fv_enc_mult_sched.sv
// Round-robin scheduler for the shared FV-encryption polynomial multiplier.
// Latency: grant and first ld_valid 1 cycle after a qualifying req; job = 2N+3 cycles + multiplier time.
// Backpressure: req is a level held until done; no grant while locked=0; mul_done is awaited only in WAIT.
//
// Optional watchdog: define FV_ENC_MULT_SCHED_TIMEOUT_EN to bound WAIT to TO_CYCLES cycles.
// Ports:
//   clk, rst (async active-high), locked (no new grant while low)
//   req/grant/done   : per-requester level request, one-hot owner, one-cycle completion pulse
//   ld_valid/ld_idx  : operand coefficient load strobe and index
//   mul_start/mul_done : multiplier start pulse and completion pulse
//   rd_valid/rd_idx  : result coefficient read strobe and index
//   busy, err        : not-IDLE flag, sticky watchdog error
module fv_enc_mult_sched #(
  parameter int N         = 16,
  parameter int NREQ      = 2,
  parameter int TO_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 locked,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      grant,
  output logic                 ld_valid,
  output logic [$clog2(N)-1:0] ld_idx,
  output logic                 mul_start,
  input  logic                 mul_done,
  output logic                 rd_valid,
  output logic [$clog2(N)-1:0] rd_idx,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 err
);

  localparam int IW = $clog2(N);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
  logic [NREQ-1:0] grant_d, done_d;
  logic            ld_valid_d, mul_start_d, rd_valid_d;
  logic [IW-1:0]   ld_idx_d, rd_idx_d;
  logic            found;
  logic [PW-1:0]   pick;
  int              cand;
  logic            timeout;

  // Round-robin search: first set req bit at or above the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        pick  = PW'(cand);
      end
    end
  end

`ifdef FV_ENC_MULT_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] wcnt_q;
  logic          err_d;

  // wcnt_q holds the number of WAIT cycles already elapsed; the TO_CYCLES-th
  // WAIT cycle without mul_done is the one that trips the watchdog.
  assign timeout = (state_q == WAIT) && (wcnt_q == CW'(TO_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
      err    <= 1'b0;
    end else begin
      wcnt_q <= (state_q == WAIT) ? wcnt_q + CW'(1) : '0;
      err    <= err_d;
    end
  end
`else
  // Watchdog compiled out: never fires, err is constant low.
  assign timeout = 1'b0 && (TO_CYCLES > 0);
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    ld_valid_d  = 1'b0;
    ld_idx_d    = '0;
    mul_start_d = 1'b0;
    rd_valid_d  = 1'b0;
    rd_idx_d    = '0;
    done_d      = '0;
`ifdef FV_ENC_MULT_SCHED_TIMEOUT_EN
    err_d       = err;
`endif
    case (state_q)
      IDLE: begin
        if (locked && found) begin
          state_d    = LOAD;
          grant_d    = NREQ'(1) << pick;
          owner_d    = pick;
          ld_valid_d = 1'b1;
        end
      end
      LOAD: begin
        if (ld_idx == IDX_LAST) begin
          state_d     = START;
          mul_start_d = 1'b1;
        end else begin
          ld_valid_d = 1'b1;
          ld_idx_d   = ld_idx + IW'(1);
        end
      end
      // mul_done here coincides with mul_start and is deliberately not looked at.
      START: state_d = WAIT;
      WAIT: begin
        if (mul_done) begin
          state_d    = DRAIN;
          rd_valid_d = 1'b1;
        end else if (timeout) begin
          // Release the owner without draining so it cannot hang.
          state_d = RELEASE;
          done_d  = grant;
`ifdef FV_ENC_MULT_SCHED_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      DRAIN: begin
        if (rd_idx == IDX_LAST) begin
          state_d = RELEASE;
          done_d  = grant;
        end else begin
          rd_valid_d = 1'b1;
          rd_idx_d   = rd_idx + IW'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = (owner_q == PTR_LAST) ? '0 : owner_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      ld_valid  <= 1'b0;
      ld_idx    <= '0;
      mul_start <= 1'b0;
      rd_valid  <= 1'b0;
      rd_idx    <= '0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      ld_valid  <= ld_valid_d;
      ld_idx    <= ld_idx_d;
      mul_start <= mul_start_d;
      rd_valid  <= rd_valid_d;
      rd_idx    <= rd_idx_d;
      done      <= done_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_fv_enc_mult_sched.sv
module tb_fv_enc_mult_sched;

  logic       clk = 1'b0;
  logic       rst, locked, mul_done;
  logic [1:0] req, grant, done;
  logic       ld_valid, mul_start, rd_valid, busy, err;
  logic [3:0] ld_idx, rd_idx;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  fv_enc_mult_sched #(.N(16), .NREQ(2), .TO_CYCLES(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .locked    (locked),
    .req       (req),
    .grant     (grant),
    .ld_valid  (ld_valid),
    .ld_idx    (ld_idx),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .rd_valid  (rd_valid),
    .rd_idx    (rd_idx),
    .done      (done),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {grant, ld_valid, ld_idx, mul_start, rd_valid, rd_idx, done, busy, err}, 32'd0);
  endtask

  // Runs one complete job: expects grant g, returns mul_done lat cycles after
  // mul_start, and leaves the caller at the RELEASE cycle (done visible).
  task automatic do_job(input logic [1:0] g, input int lat, input string tag);
    int n = 0;
    while (grant == 2'b00 && n < 8) begin
      cyc();
      n++;
    end
    chk({tag, " grant"}, grant, g);
    for (int k = 0; k < 16; k++) begin
      chk({tag, " load"}, {ld_valid, ld_idx, mul_start}, {1'b1, 4'(k), 1'b0});
      cyc();
    end
    chk({tag, " start"}, {mul_start, ld_valid, ld_idx}, {1'b1, 1'b0, 4'd0});
    for (int j = 0; j < lat; j++) begin
      cyc();
      if (j == 0) chk({tag, " start pulse width"}, mul_start, 1'b0);
    end
    chk({tag, " wait"}, {rd_valid, busy}, {1'b0, 1'b1});
    mul_done = 1'b1;
    cyc();
    mul_done = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk({tag, " drain"}, {rd_valid, rd_idx, ld_valid}, {1'b1, 4'(k), 1'b0});
      cyc();
    end
    chk({tag, " done"}, {done, grant, busy, rd_valid, err}, {g, g, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    bit bad;
    rst = 1'b1; locked = 1'b1; req = 2'b00; mul_done = 1'b0;
    cyc(); cyc();
    chk_zero("reset values");
    rst = 1'b0;
    cyc();
    chk_zero("idle after reset");

    // Single job
    req = 2'b01;
    cyc();
    chk("single grant latency", {grant, ld_valid, ld_idx}, {2'b01, 1'b1, 4'd0});
    do_job(2'b01, 20, "single");
    req = 2'b00;
    cyc();
    chk("single released", {grant, busy, done}, 32'd0);
    cyc();
    chk("single stays idle", {grant, busy}, 32'd0);

    // Contention from a fresh pointer
    rst = 1'b1; cyc(); rst = 1'b0; req = 2'b11;
    do_job(2'b01, 3, "rr1"); cyc(); chk("rr1 gap", {grant, busy, done}, 32'd0);
    do_job(2'b10, 4, "rr2"); cyc(); chk("rr2 gap", {grant, busy, done}, 32'd0);
    do_job(2'b01, 2, "rr3"); cyc(); chk("rr3 gap", {grant, busy, done}, 32'd0);
    do_job(2'b10, 1, "rr4");
    req = 2'b00;
    cyc();
    chk("rr4 gap", {grant, busy, done}, 32'd0);

    // Lock gating
    rst = 1'b1; cyc(); rst = 1'b0;
    locked = 1'b0; req = 2'b01;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (grant != 2'b00 || busy != 1'b0) bad = 1'b1;
    end
    chk("lock gate holds", bad, 1'b0);
    locked = 1'b1;
    cyc();
    chk("lock rise grant", {grant, ld_valid, ld_idx}, {2'b01, 1'b1, 4'd0});

    // Mid-job reset during DRAIN at rd_idx 7
    for (int k = 0; k < 16; k++) cyc();
    chk("abort start", mul_start, 1'b1);
    cyc(); cyc();
    mul_done = 1'b1; cyc(); mul_done = 1'b0;
    for (int k = 0; k < 7; k++) cyc();
    chk("abort at idx7", {rd_valid, rd_idx}, {1'b1, 4'd7});
    rst = 1'b1;
    #1;
    chk_zero("async reset mid drain");
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (done != 2'b00) bad = 1'b1;
    end
    chk("no done on abort", bad, 1'b0);
    rst = 1'b0;
    cyc();
    chk("fresh job after abort", {grant, ld_valid, ld_idx, done}, {2'b01, 1'b1, 4'd0, 2'b00});

    // Stray mul_done in LOAD and in the mul_start cycle
    for (int k = 0; k < 16; k++) begin
      chk("stray load", {ld_valid, ld_idx}, {1'b1, 4'(k)});
      mul_done = (k == 3);
      cyc();
    end
    mul_done = 1'b0;
    chk("stray start", {mul_start, rd_valid}, {1'b1, 1'b0});
    mul_done = 1'b1;
    cyc();
    mul_done = 1'b0;
    chk("done with start ignored", {rd_valid, busy}, {1'b0, 1'b1});
    for (int i = 0; i < 4; i++) cyc();
    chk("still waiting", {rd_valid, busy}, {1'b0, 1'b1});
    mul_done = 1'b1;
    cyc();
    mul_done = 1'b0;
    chk("drain after done", {rd_valid, rd_idx}, {1'b1, 4'd0});
    for (int i = 0; i < 16; i++) cyc();
    chk("stray job done", {done, rd_valid}, {2'b01, 1'b0});
    req = 2'b00;
    cyc(); cyc();
    chk("stray idle", {grant, busy, err}, 32'd0);

`ifdef FV_ENC_MULT_SCHED_TIMEOUT_EN
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 2'b01;
    cyc();
    chk("to grant", grant, 2'b01);
    for (int k = 0; k < 16; k++) cyc();
    chk("to start", mul_start, 1'b1);
    bad = 1'b0;
    for (int j = 0; j < 64; j++) begin
      cyc();
      if (done != 2'b00 || rd_valid) bad = 1'b1;
    end
    chk("to quiet in wait", bad, 1'b0);
    chk("to before limit", {done, err, busy}, {2'b00, 1'b0, 1'b1});
    cyc();
    chk("to fires", {done, err, rd_valid, grant}, {2'b01, 1'b1, 1'b0, 2'b01});
    req = 2'b00;
    cyc();
    chk("to released", {done, err, busy}, {2'b00, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++) cyc();
    chk("to err sticky", err, 1'b1);
    rst = 1'b1;
    #1;
    chk("to err cleared by rst", err, 1'b0);
    cyc();
    rst = 1'b0;
`else
    // Long multiplier stall: no watchdog, WAIT must persist and err stays low.
    req = 2'b01;
    cyc();
    for (int k = 0; k < 16; k++) cyc();
    for (int j = 0; j < 100; j++) cyc();
    chk("no watchdog wait", {busy, done, rd_valid, err}, {1'b1, 2'b00, 1'b0, 1'b0});
    rst = 1'b1; cyc(); rst = 1'b0; req = 2'b00;
    cyc();
    chk_zero("idle after stall reset");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
